mem_access_controller: RTL and testbench

Sequencer for the MEM stage and the MEM/WB pipeline register of the 5-stage MIPS core when data memory has variable latency. It handshakes each load/store in MEM with the data memory via req/ack, stalls IF/ID/EX/MEM while the access is outstanding, and drives a bubble into MEM/WB until read data is valid. It also counts stall cycles for performance reporting and can optionally trap hung accesses with a watchdog.

---
 rtl/mem_access_controller_pkg.sv | 12 +
 rtl/mem_wait_timer.sv | 25 ++
 rtl/mem_access_controller.sv | 131 +++++++++++++
 tb/tb_mem_access_controller.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the MEM-stage access sequencer: state encodings and default watchdog limit.
package mem_access_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit WAIT-cycle counter for the MEM access watchdog (used only when MEM_TIMEOUT_EN is defined).
module mem_wait_timer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic       Inc,
    input  logic [7:0] Limit,
    output logic       Terminal
);

    logic [7:0] waitCnt;

    // Load starts at 1 because the cycle that enters WAIT already counts as one wait cycle.
    always_ff @(posedge Clk) begin
        if (Reset)
            waitCnt <= 8'd0;
        else if (Load)
            waitCnt <= 8'd1;
        else if (Inc && waitCnt != 8'hFF)
            waitCnt <= waitCnt + 8'd1;
    end

    assign Terminal = (waitCnt == Limit);

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage req/ack sequencer with pipeline stall, MEM/WB bubble and stall-cycle counter.
// Optional hung-access watchdog built when MEM_TIMEOUT_EN is defined.
module mem_access_controller
    import mem_access_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             MemAckI,
    output logic             MemReqO,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushW,
    output logic [CNT_W-1:0] StallCycles,
    output logic             MemErr
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    state_t           state, nextState;
    logic             access, stall, flush, req;
    logic [CNT_W-1:0] stallCnt;

    assign access = MemReadM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
    logic timerLoad, timerInc, terminal, memErrQ;
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    mem_wait_timer uTimer (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (timerLoad),
        .Inc      (timerInc),
        .Limit    (TimeoutLimit),
        .Terminal (terminal)
    );
`endif

    // Mealy decode; Reset forces every control output low in the same cycle.
    always_comb begin
        nextState = state;
        req       = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timerLoad = 1'b0;
        timerInc  = 1'b0;
`endif
        if (!Reset) begin
            case (state)
                S_IDLE: begin
                    req = access;
                    if (access && !MemAckI) begin
                        stall     = 1'b1;
                        flush     = 1'b1;
                        nextState = S_WAIT;
`ifdef MEM_TIMEOUT_EN
                        timerLoad = 1'b1;
`endif
                    end
                end
                S_WAIT: begin
                    req = 1'b1;
                    if (MemAckI) begin
                        nextState = S_IDLE;
                    end else begin
                        stall = 1'b1;
                        flush = 1'b1;
`ifdef MEM_TIMEOUT_EN
                        timerInc = 1'b1;
                        if (terminal)
                            nextState = S_ERR;
`endif
                    end
                end
`ifdef MEM_TIMEOUT_EN
                S_ERR: begin
                    stall = 1'b1;
                    flush = 1'b1;
                end
`endif
                default: nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            stallCnt <= '0;
        else if (stall && stallCnt != {CNT_W{1'b1}})
            stallCnt <= stallCnt + 1'b1;
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            memErrQ <= 1'b0;
        else if (nextState == S_ERR)
            memErrQ <= 1'b1;
    end

    assign MemErr = memErrQ & ~Reset;
`else
    assign MemErr = 1'b0;
`endif

    assign MemReqO     = req;
    assign StallF      = stall;
    assign StallD      = stall;
    assign StallE      = stall;
    assign StallM      = stall;
    assign FlushW      = flush;
    assign StallCycles = Reset ? '0 : stallCnt;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller; watchdog steps run when MEM_TIMEOUT_EN is defined.
module tb_mem_access_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, MemAckI = 1'b0;
    logic        MemReqO, StallF, StallD, StallE, StallM, FlushW, MemErr;
    logic [31:0] StallCycles;
    logic        MemReqO2, StallF2, StallD2, StallE2, StallM2, FlushW2, MemErr2;
    logic [1:0]  StallCycles2;

    int checks = 0;
    int errors = 0;
    int expCnt = 0;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    mem_access_controller #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .MemAckI(MemAckI), .MemReqO(MemReqO), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .StallM(StallM), .FlushW(FlushW),
        .StallCycles(StallCycles), .MemErr(MemErr)
    );

    // Narrow counter copy to observe saturation.
    mem_access_controller #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .MemAckI(MemAckI), .MemReqO(MemReqO2), .StallF(StallF2), .StallD(StallD2),
        .StallE(StallE2), .StallM(StallM2), .FlushW(FlushW2),
        .StallCycles(StallCycles2), .MemErr(MemErr2)
    );

    task automatic step(input logic rst, input logic rd, input logic wr, input logic ack,
                        input logic eReq, input logic eStall, input logic eFlush,
                        input logic eErr, input string tag);
        exp_t e;
        logic [6:0] ctl, ctl2;
        @(posedge Clk);
        #1;
        Reset = rst; MemReadM = rd; MemWriteM = wr; MemAckI = ack;
        e.ctl  = {eReq, eStall, eStall, eStall, eStall, eFlush, eErr};
        e.cnt  = rst ? 32'd0 : 32'(expCnt);
        e.cnt2 = rst ? 2'd0 : ((expCnt > 3) ? 2'd3 : 2'(expCnt));
        sb.push_back(e);
        @(negedge Clk);
        e = sb.pop_front();
        ctl  = {MemReqO, StallF, StallD, StallE, StallM, FlushW, MemErr};
        ctl2 = {MemReqO2, StallF2, StallD2, StallE2, StallM2, FlushW2, MemErr2};
        checks++;
        assert (ctl === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl(req,stFDEM,flush,err) observed=%b expected=%b", tag, ctl, e.ctl);
        end
        checks++;
        assert (StallCycles === e.cnt) else begin
            errors++;
            $error("FAIL %s StallCycles observed=%0d expected=%0d", tag, StallCycles, e.cnt);
        end
        checks++;
        assert (ctl2 === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl2 observed=%b expected=%b", tag, ctl2, e.ctl);
        end
        checks++;
        assert (StallCycles2 === e.cnt2) else begin
            errors++;
            $error("FAIL %s StallCycles2 observed=%0d expected=%0d", tag, StallCycles2, e.cnt2);
        end
        if (rst) expCnt = 0;
        else if (eStall) expCnt++;
    endtask

    initial begin
        // Reset with an access pending: everything forced low.
        step(1, 1, 0, 0,  0, 0, 0, 0, "reset0");
        step(1, 0, 1, 1,  0, 0, 0, 0, "reset1");
        step(0, 0, 0, 1,  0, 0, 0, 0, "idle_ack_ignored");

        step(0, 1, 0, 1,  1, 0, 0, 0, "zero_wait_load");
        step(0, 0, 0, 0,  0, 0, 0, 0, "idle_after_zw");

        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0,  1, 1, 1, 0, $sformatf("store_wait%0d", i));
        step(0, 0, 1, 1,  1, 0, 0, 0, "store_ack");
        step(0, 0, 0, 0,  0, 0, 0, 0, "store_cnt3");

        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 0,  1, 1, 1, 0, $sformatf("b2b%0d_w0", k));
            step(0, 1, 0, 0,  1, 1, 1, 0, $sformatf("b2b%0d_w1", k));
            step(0, 1, 0, 1,  1, 0, 0, 0, $sformatf("b2b%0d_ack", k));
        end
        step(0, 0, 0, 0,  0, 0, 0, 0, "b2b_cnt7");

        // Reset in the second WAIT cycle abandons the access.
        step(0, 1, 0, 0,  1, 1, 1, 0, "rstwait_enter");
        step(0, 1, 0, 0,  1, 1, 1, 0, "rstwait_w1");
        step(1, 1, 0, 0,  0, 0, 0, 0, "rstwait_reset");
        step(0, 0, 0, 1,  0, 0, 0, 0, "rstwait_late_ack");
        step(0, 1, 0, 1,  1, 0, 0, 0, "rstwait_zw_after");

`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 0,  1, 1, 1, 0, $sformatf("wd_cyc%0d", i));
        step(0, 0, 1, 0,  0, 1, 1, 1, "wd_err");
        step(0, 0, 1, 1,  0, 1, 1, 1, "wd_err_ack");
        step(0, 0, 0, 0,  0, 1, 1, 1, "wd_err_hold");
        step(1, 0, 0, 0,  0, 0, 0, 0, "wd_reset");
        step(0, 0, 0, 0,  0, 0, 0, 0, "wd_after_reset");
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0,  1, 1, 1, 0, $sformatf("wdack_cyc%0d", i));
        step(0, 1, 0, 1,  1, 0, 0, 0, "wdack_terminal_ack");
        step(0, 0, 0, 0,  0, 0, 0, 0, "wdack_idle");
`else
        for (int i = 0; i < 20; i++)
            step(0, 0, 1, 0,  1, 1, 1, 0, $sformatf("long_wait%0d", i));
        step(0, 0, 1, 1,  1, 0, 0, 0, "long_ack");
        step(0, 0, 0, 0,  0, 0, 0, 0, "long_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
